// File: rtl/wfg_drive_pwm.sv
// wfg_drive_pwm: turns each AXI-Stream sample into the duty value of one PWM
// period on a single pin. A one-entry skid buffer sits between the stream and
// the period timer, so the next sample can be fetched while a period runs.
// If no sample is waiting at a period boundary, the last duty repeats and a
// saturating underrun counter advances.
//
//   state | meaning
//   IDLE  | no period running, pin parked at inactive level
//   RUN   | periods running, buffer consumed at each boundary
module wfg_drive_pwm #(
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ctrl_en_q_i,
  input  logic [CNT_W-1:0] cfg_period_q_i,
  input  logic             cfg_pol_q_i,
  output logic             wfg_axis_tready_o,
  input  logic             wfg_axis_tvalid_i,
  input  logic [31:0]      wfg_axis_tdata_i,
  output logic             pwm_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] underrun_cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0] buf_data_q, buf_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] under_q, under_d;
  logic             xfer;

  // Sample bits above the duty width carry no meaning for this block.
  logic unused_tdata_hi;
  assign unused_tdata_hi = ^wfg_axis_tdata_i[31:CNT_W];

  // No bypass: a boundary consuming the buffer keeps tready low that cycle.
  assign wfg_axis_tready_o = ctrl_en_q_i & ~buf_valid_q & ~wb_rst_i;
  assign xfer              = wfg_axis_tvalid_i & wfg_axis_tready_o;

  assign pwm_o          = pwm_q;
  assign busy_o         = (state_q == S_RUN);
  assign underrun_cnt_o = under_q;

  // Next-state, buffer, period timer and output level.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    period_d    = period_q;
    pwm_d       = pwm_q;
    under_d     = under_q;

    if (!ctrl_en_q_i) begin
      // Disable flushes the buffer but keeps the underrun history.
      state_d     = S_IDLE;
      buf_valid_d = 1'b0;
      cnt_d       = '0;
      pwm_d       = cfg_pol_q_i;
    end else begin
      if (xfer) begin
        buf_valid_d = 1'b1;
        buf_data_d  = wfg_axis_tdata_i[CNT_W-1:0];
      end
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          pwm_d = cfg_pol_q_i;
          if (buf_valid_q) begin
            state_d     = S_RUN;
            duty_d      = buf_data_q;
            period_d    = cfg_period_q_i;
            buf_valid_d = 1'b0;
          end
        end
        S_RUN: begin
          pwm_d = (cnt_q < duty_q) ^ cfg_pol_q_i;
          if (cnt_q == period_q) begin
            cnt_d    = '0;
            period_d = cfg_period_q_i;
            if (buf_valid_q) begin
              duty_d      = buf_data_q;
              buf_valid_d = 1'b0;
            end else if (under_q != {CNT_W{1'b1}}) begin
              under_d = under_q + ONE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      cnt_q       <= '0;
      duty_q      <= '0;
      period_q    <= '0;
      pwm_q       <= 1'b0;
      under_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      period_q    <= period_d;
      pwm_q       <= pwm_d;
      under_q     <= under_d;
    end
  end

endmodule

// File: tb/tb_wfg_drive_pwm.sv
// Bench for wfg_drive_pwm. Accepted samples go into a scoreboard queue; a
// reference model expands each period into a queue of expected active bits,
// and a monitor compares the pin, busy, tready and underrun count every cycle.
module tb_wfg_drive_pwm;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         en       = 1'b0;
  logic [W-1:0] per      = '0;
  logic         pol      = 1'b0;
  logic         tvalid   = 1'b0;
  logic [31:0]  tdata    = '0;
  logic         tready;
  logic         pwm;
  logic         busy;
  logic [W-1:0] under;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: sb_q holds accepted duties not yet used, bits_q the
  // active/inactive pattern still to be emitted for the current period.
  bit m_ok    = 1'b0;
  bit m_run   = 1'b0;
  bit m_pwm   = 1'b0;
  bit m_busy  = 1'b0;
  int m_under = 0;
  int m_last  = 0;
  bit bits_q[$];
  int sb_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  wfg_drive_pwm #(.CNT_W(W)) dut (
    .wb_clk_i          (wb_clk_i),
    .wb_rst_i          (wb_rst_i),
    .ctrl_en_q_i       (en),
    .cfg_period_q_i    (per),
    .cfg_pol_q_i       (pol),
    .wfg_axis_tready_o (tready),
    .wfg_axis_tvalid_i (tvalid),
    .wfg_axis_tdata_i  (tdata),
    .pwm_o             (pwm),
    .busy_o            (busy),
    .underrun_cnt_o    (under)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void start_period(input int d, input int p);
    m_last = d;
    for (int i = 0; i <= p; i++) bits_q.push_back(i < d);
  endfunction

  // Advance the model across one clock edge using the inputs present now.
  task automatic model_step();
    bit acc;
    int d_in;
    acc  = tvalid && en && !wb_rst_i && (sb_q.size() == 0);
    d_in = int'(tdata[W-1:0]);
    if (wb_rst_i) begin
      m_ok = 1'b1; m_run = 1'b0; m_pwm = 1'b0; m_busy = 1'b0;
      m_under = 0; m_last = 0;
      bits_q.delete(); sb_q.delete();
    end else if (!en) begin
      m_run = 1'b0; m_busy = 1'b0; m_pwm = pol;
      bits_q.delete(); sb_q.delete();
    end else begin
      if (!m_run) begin
        m_pwm = pol;
        if (sb_q.size() > 0) begin
          m_run  = 1'b1;
          m_busy = 1'b1;
          start_period(sb_q.pop_front(), int'(per));
        end
      end else begin
        m_pwm = bits_q.pop_front() ^ pol;
        if (bits_q.size() == 0) begin
          if (sb_q.size() > 0) begin
            start_period(sb_q.pop_front(), int'(per));
          end else begin
            if (m_under < MAXV) m_under++;
            start_period(m_last, int'(per));
          end
        end
      end
      if (acc) sb_q.push_back(d_in);
    end
  endtask

  // Monitor: outputs here reflect the previous edge; inputs are for the next.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (m_ok) begin
        check("pwm_o", 32'(pwm), 32'(m_pwm));
        check("busy_o", 32'(busy), 32'(m_busy));
        check("underrun_cnt_o", 32'(under), 32'(m_under));
        check("tready", 32'(tready), 32'(en & ~wb_rst_i & (sb_q.size() == 0)));
      end
      model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Present one sample and return just after the edge that accepts it.
  task automatic send(input int d);
    int waited;
    waited = 0;
    tvalid = 1'b1;
    tdata  = $urandom();
    tdata[W-1:0] = d[W-1:0];
    @(negedge wb_clk_i);
    while (!tready && waited < 100) begin
      waited++;
      @(negedge wb_clk_i);
    end
    if (!tready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: sample %0d not accepted within 100 cycles (t=%0t)", d, $time);
      tvalid = 1'b0;
    end
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic expect_pwm(input string name, input int n, input logic val);
    for (int k = 0; k < n; k++) begin
      check(name, 32'(pwm), 32'(val));
      tick(1);
    end
  endtask

  task automatic reset_pulse();
    wb_rst_i = 1'b1;
    tick(1);
    check("rst_pwm", 32'(pwm), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_underrun", 32'(under), 32'(0));
    check("rst_tready", 32'(tready), 32'(0));
    wb_rst_i = 1'b0;
  endtask

  initial begin
    int highs;
    int gap;

    tick(3);
    check("init_pwm", 32'(pwm), 32'(0));
    check("init_busy", 32'(busy), 32'(0));
    check("init_underrun", 32'(under), 32'(0));
    check("init_tready", 32'(tready), 32'(0));
    wb_rst_i = 1'b0;

    // Basic duty: 3 then 7 with period 10, stream held valid.
    en = 1'b1; pol = 1'b0; per = 4'd9;
    send(3);
    send(7);
    tvalid = 1'b0;
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (pwm) highs++;
      tick(1);
    end
    check("duty3_highs", 32'(highs), 32'(3));
    check("duty_busy", 32'(busy), 32'(1));
    check("duty_no_underrun", 32'(under), 32'(0));
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (pwm) highs++;
      tick(1);
    end
    check("duty7_highs", 32'(highs), 32'(7));

    // Underrun: one sample of 2, then three starved boundaries.
    reset_pulse();
    per = 4'd4;
    send(2);
    tvalid = 1'b0;
    tick(16);
    check("underrun_3", 32'(under), 32'(3));
    send(5);
    tvalid = 1'b0;
    tick(5);
    expect_pwm("duty_gt_period", 5, 1'b1);

    // Edge duties and a one-clock period.
    reset_pulse();
    per = 4'd7;
    send(0);
    tvalid = 1'b0;
    tick(2);
    expect_pwm("duty_zero", 8, 1'b0);
    send(12);
    tvalid = 1'b0;
    tick(8);
    expect_pwm("duty_12_per_7", 8, 1'b1);
    per = 4'd0;
    send(1);
    send(0);
    send(1);
    tvalid = 1'b0;
    tick(10);

    // Polarity plus randomized samples, gaps, period and polarity changes.
    reset_pulse();
    pol = 1'b1; per = 4'd9;
    send(3);
    tvalid = 1'b0;
    tick(25);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) per = W'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) pol = ~pol;
      send(int'($urandom_range(0, MAXV)));
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        tvalid = 1'b0;
        tick(gap);
      end
    end
    tvalid = 1'b0;
    tick(30);

    // Disable mid-period flushes a stale buffered sample; then reset mid-run.
    pol = 1'b0; per = 4'd9;
    reset_pulse();
    send(6);
    send(9);
    tvalid = 1'b0;
    tick(3);
    en = 1'b0;
    tick(1);
    check("dis_pwm", 32'(pwm), 32'(0));
    check("dis_busy", 32'(busy), 32'(0));
    check("dis_tready", 32'(tready), 32'(0));
    en = 1'b1;
    send(2);
    tvalid = 1'b0;
    tick(1);
    check("reen_busy", 32'(busy), 32'(1));
    tick(1);
    expect_pwm("reen_high", 2, 1'b1);
    expect_pwm("reen_low", 1, 1'b0);
    tick(8);
    check("reen_underrun", 32'(under), 32'(1));
    reset_pulse();

    // Period change mid-period: current period completes, next uses new length.
    per = 4'd9;
    send(5);
    send(2);
    tvalid = 1'b0;
    tick(4);
    per = 4'd3;
    tick(6);
    for (int k = 0; k < 8; k++) begin
      check("per_change", 32'(pwm), 32'((k % 4) < 2));
      tick(1);
    end

    // Saturation: one-clock periods with no samples.
    per = 4'd0;
    tick(30);
    check("underrun_sat", 32'(under), 32'(MAXV));

    en = 1'b0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
